// File: rtl/jk_bank_arbiter.sv
// Round-robin arbitrated access to a shared bank of JK flip-flops.
// A 2-state FSM accepts one J/K command in IDLE and commits it to the bank in APPLY.
module jk_bank_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  localparam int GW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_j,
  input  logic [N_REQ*WIDTH-1:0] req_k,
  output logic [N_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       q_bar,
  output logic [GW-1:0]          grant_id,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_APPLY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [GW-1:0]     r_rr_ptr;
  logic [GW-1:0]     r_grant_id;
  logic [WIDTH-1:0]  r_q;
  logic [WIDTH-1:0]  r_j;
  logic [WIDTH-1:0]  r_k;
  logic [WIDTH-1:0]  w_q_nxt;
  logic [GW-1:0]     w_pick;
  logic              w_any_valid;
  logic              w_accept;
  logic              w_apply;

  // First valid index strictly after ptr, wrapping modulo N_REQ; the
  // previous winner is therefore always searched last.
  function automatic logic [GW-1:0] f_pick(
    input logic [N_REQ-1:0] valid,
    input logic [GW-1:0]    ptr
  );
    logic [GW-1:0] sel;
    logic          hit;
    int unsigned   idx;
    sel = '0;
    hit = 1'b0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx = (int'(ptr) + off) % N_REQ;
      if (!hit && valid[idx]) begin
        sel = idx[GW-1:0];
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

  assign w_any_valid = |req_valid;
  assign w_pick      = f_pick(req_valid, r_rr_ptr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ready is gated by reset so no requester sees an accept while the bank is held.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_accept    = 1'b0;
    w_apply     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_valid && rst) begin
          w_accept          = 1'b1;
          req_ready[w_pick] = 1'b1;
          w_state_nxt       = S_APPLY;
        end
      end
      S_APPLY: begin
        w_apply     = 1'b1;
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr   <= GW'(N_REQ - 1);
      r_grant_id <= '0;
      r_j        <= '0;
      r_k        <= '0;
    end else if (w_accept) begin
      r_rr_ptr   <= w_pick;
      r_grant_id <= w_pick;
      r_j        <= req_j[w_pick*WIDTH +: WIDTH];
      r_k        <= req_k[w_pick*WIDTH +: WIDTH];
    end
  end

  // Characteristic equation q+ = J&~q | ~K&q covers hold, clear, set and toggle.
  assign w_q_nxt = (r_j & ~r_q) | (~r_k & r_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (w_apply) begin
      r_q <= w_q_nxt;
    end
  end

  assign q        = r_q;
  assign q_bar    = ~r_q;
  assign grant_id = r_grant_id;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed self-checking bench for jk_bank_arbiter (N_REQ=4, WIDTH=8).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_jk_bank_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_j;
  logic [N*W-1:0] req_k;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   q;
  logic [W-1:0]   q_bar;
  logic [1:0]     grant_id;
  logic           busy;
  logic           done;

  int n_vec;
  int n_err;

  jk_bank_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_j     (req_j),
    .req_k     (req_k),
    .req_ready (req_ready),
    .q         (q),
    .q_bar     (q_bar),
    .grant_id  (grant_id),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int idx, input logic v, input logic [W-1:0] j,
                         input logic [W-1:0] k);
    req_valid[idx]       = v;
    req_j[idx*W +: W]    = j;
    req_k[idx*W +: W]    = k;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_vec++; if (q !== 8'h00) begin n_err++; $display("FAIL rst_q got %h exp 00", q); end
    n_vec++; if (q_bar !== 8'hFF) begin n_err++; $display("FAIL rst_qbar got %h exp ff", q_bar); end
    n_vec++; if ({busy, done, req_ready, grant_id} !== 8'h00)
      begin n_err++; $display("FAIL rst_ctrl got busy=%b done=%b rdy=%b gid=%0d exp all 0", busy, done, req_ready, grant_id); end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    // Start a set-all command on requester 0, then reset during its APPLY cycle.
    @(negedge clk);
    set_req(0, 1'b1, 8'hFF, 8'h00);
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rst_first_ready got %b exp 0001", req_ready); end
    @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_in_apply busy got %b exp 1", busy); end
    rst = 1'b0;
    #1;
    n_vec++; if ({q, q_bar} !== 16'h00FF) begin n_err++; $display("FAIL rst_async_q got q=%h qb=%h exp 00/ff", q, q_bar); end
    n_vec++; if ({busy, done, req_ready} !== 6'b0) begin n_err++; $display("FAIL rst_async_ctrl got busy=%b done=%b rdy=%b exp 0", busy, done, req_ready); end
    @(negedge clk);
    n_vec++; if (q !== 8'h00) begin n_err++; $display("FAIL rst_no_partial got %h exp 00", q); end
    set_req(0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    // Pointer is back at 3 after reset; only requester 1 asks.
    set_req(1, 1'b1, 8'hF0, 8'h00);
    #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL single_ready got %b exp 0010", req_ready); end
    @(negedge clk);
    set_req(1, 1'b0, 8'h00, 8'h00);
    #1;
    n_vec++; if ({busy, done, req_ready} !== 6'b110000) begin n_err++; $display("FAIL single_apply got busy=%b done=%b rdy=%b exp 1/1/0000", busy, done, req_ready); end
    n_vec++; if (grant_id !== 2'd1) begin n_err++; $display("FAIL single_gid got %0d exp 1", grant_id); end
    n_vec++; if (q !== 8'h00) begin n_err++; $display("FAIL single_q_early got %h exp 00", q); end
    @(negedge clk);
    n_vec++; if ({q, q_bar} !== 16'hF00F) begin n_err++; $display("FAIL single_q got q=%h qb=%h exp f0/0f", q, q_bar); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle busy got %b exp 0", busy); end
  endtask

  task automatic test_truth_table();
    // q=F0, J=CC, K=AA: per bit toggle/set/clear/hold gives 5C.
    set_req(3, 1'b1, 8'hCC, 8'hAA);
    #1;
    n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL truth_ready got %b exp 1000", req_ready); end
    @(negedge clk);
    set_req(3, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    n_vec++; if (q !== 8'h5C) begin n_err++; $display("FAIL truth_q got %h exp 5c", q); end
    n_vec++; if (q_bar !== 8'hA3) begin n_err++; $display("FAIL truth_qbar got %h exp a3", q_bar); end
    n_vec++; if (grant_id !== 2'd3) begin n_err++; $display("FAIL truth_gid got %0d exp 3", grant_id); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_order [5];
    exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'h00, 8'h00);
    for (int g = 0; g < 5; g++) begin
      #1;
      n_vec++; if (req_ready !== (4'b0001 << exp_order[g]))
        begin n_err++; $display("FAIL rr_ready[%0d] got %b exp %b", g, req_ready, 4'b0001 << exp_order[g]); end
      @(negedge clk);
      #1;
      n_vec++; if ({busy, req_ready, grant_id} !== {1'b1, 4'b0000, exp_order[g]})
        begin n_err++; $display("FAIL rr_apply[%0d] got busy=%b rdy=%b gid=%0d exp 1/0000/%0d", g, busy, req_ready, grant_id, exp_order[g]); end
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'h00, 8'h00);
    #1;
    n_vec++; if (q !== 8'h5C) begin n_err++; $display("FAIL rr_hold_q got %h exp 5c", q); end
  endtask

  task automatic test_withdraw();
    set_req(0, 1'b1, 8'h00, 8'h00);
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL wd_ready0 got %b exp 0001", req_ready); end
    @(negedge clk);
    set_req(0, 1'b0, 8'h00, 8'h00);
    set_req(2, 1'b1, 8'hFF, 8'h00);
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL wd_apply_ready got %b exp 0000", req_ready); end
    @(negedge clk);
    set_req(2, 1'b0, 8'h00, 8'h00);
    #1;
    n_vec++; if ({busy, req_ready} !== 5'b0) begin n_err++; $display("FAIL wd_idle got busy=%b rdy=%b exp 0/0000", busy, req_ready); end
    @(negedge clk); @(negedge clk);
    n_vec++; if ({busy, q, grant_id} !== {1'b0, 8'h5C, 2'd0})
      begin n_err++; $display("FAIL wd_after got busy=%b q=%h gid=%0d exp 0/5c/0", busy, q, grant_id); end
  endtask

  task automatic test_back_to_back_toggle();
    logic [W-1:0] exp_q [3];
    exp_q = '{8'hFF, 8'h00, 8'hFF};
    set_req(1, 1'b1, 8'h00, 8'hFF);
    @(negedge clk);
    set_req(1, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    n_vec++; if (q !== 8'h00) begin n_err++; $display("FAIL tog_clear got %h exp 00", q); end
    // Requester 2 holds a toggle-all command across three consecutive grants.
    set_req(2, 1'b1, 8'hFF, 8'hFF);
    for (int g = 0; g < 3; g++) begin
      #1;
      n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL tog_ready[%0d] got %b exp 0100", g, req_ready); end
      @(negedge clk);
      @(negedge clk);
      n_vec++; if ({q, q_bar} !== {exp_q[g], ~exp_q[g]})
        begin n_err++; $display("FAIL tog_q[%0d] got q=%h qb=%h exp %h/%h", g, q, q_bar, exp_q[g], ~exp_q[g]); end
    end
    set_req(2, 1'b0, 8'h00, 8'h00);
    @(negedge clk); @(negedge clk);
    n_vec++; if ({busy, q} !== {1'b0, 8'hFF}) begin n_err++; $display("FAIL tog_final got busy=%b q=%h exp 0/ff", busy, q); end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b0;
    req_valid = '0;
    req_j     = '0;
    req_k     = '0;
    test_reset();
    test_single();
    test_truth_table();
    test_round_robin();
    test_withdraw();
    test_back_to_back_toggle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
